// File: rtl/alu_issue_stage_if.sv
// Bundle interface between register-read, the ALU issue stage and EX.
interface alu_issue_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned FUNCW = 3;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic               out_valid;
    logic               out_ready;
    logic [FUNCW-1:0]   alu_func;
    logic               alu_sub_en;
    logic [XLEN-1:0]    alu_din1;
    logic [XLEN-1:0]    alu_din2;
    logic [REGW-1:0]    rd;
    logic               rd_we;
    logic               illegal;

    // Upstream/downstream environment view.
    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_func, alu_sub_en, alu_din1, alu_din2,
               rd, rd_we, illegal
    );

    // Issue-stage view.
    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_func, alu_sub_en, alu_din1, alu_din2,
               rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decode/issue stage: one pipeline register with stall and flush.
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned FUNCW = 3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_ADD     = 3'b000;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REGW-1:0]  rd_field;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_u;
    logic             is_shift;

    logic             dec_legal;
    logic [FUNCW-1:0] dec_func;
    logic             dec_sub;
    logic [XLEN-1:0]  dec_din1;
    logic [XLEN-1:0]  dec_din2;
    logic             dec_rd_we;
    logic             load;

    // Instruction field extraction.
    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign funct7   = bus.instr[31:25];
    assign rd_field = bus.instr[11:7];
    assign imm_i    = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign imm_u    = {bus.instr[31:12], 12'b0};
    assign is_shift = (funct3[1:0] == 2'b01);

    // Accept whenever the register is empty or being drained this cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    // Decode into ALU function/operands; anything unrecognised stays at the zeroed illegal bundle.
    always_comb begin
        dec_legal = 1'b0;
        dec_func  = '0;
        dec_sub   = 1'b0;
        dec_din1  = '0;
        dec_din2  = '0;
        case (opcode)
            OPC_OP: begin
                if ((funct3 != F3_SLT) &&
                    ((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == F3_ADD)))) begin
                    dec_legal = 1'b1;
                    dec_func  = funct3;
                    dec_sub   = (funct7 == F7_ALT);
                    dec_din1  = bus.rs1_data;
                    dec_din2  = bus.rs2_data;
                end
            end
            OPC_OP_IMM: begin
                if ((funct3 != F3_SLT) && (!is_shift || (funct7 == F7_BASE))) begin
                    dec_legal = 1'b1;
                    dec_func  = funct3;
                    dec_din1  = bus.rs1_data;
                    dec_din2  = imm_i;
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_din2  = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_din1  = bus.pc;
                dec_din2  = imm_u;
            end
            default: begin
            end
        endcase
        dec_rd_we = dec_legal && (rd_field != '0);
    end

    // Issue register: flush beats load, load beats drain; data holds unless loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.alu_func   <= '0;
            bus.alu_sub_en <= 1'b0;
            bus.alu_din1   <= '0;
            bus.alu_din2   <= '0;
            bus.rd         <= '0;
            bus.rd_we      <= 1'b0;
            bus.illegal    <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid  <= 1'b0;
        end else if (load) begin
            bus.out_valid  <= 1'b1;
            bus.alu_func   <= dec_func;
            bus.alu_sub_en <= dec_sub;
            bus.alu_din1   <= dec_din1;
            bus.alu_din2   <= dec_din2;
            bus.rd         <= rd_field;
            bus.rd_we      <= dec_rd_we;
            bus.illegal    <= !dec_legal;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed table, corner sequences, random vs model.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [2:0]  func;
        logic        sub;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        bundle_t     exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t    vecs [16];
    logic    m_valid;
    bundle_t m_b;

    function automatic bundle_t mk(input logic [2:0] f, input logic s, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] r, input logic w,
                                   input logic il);
        bundle_t t;
        t.func = f; t.sub = s; t.d1 = x; t.d2 = y; t.rd = r; t.we = w; t.ill = il;
        return t;
    endfunction

    function automatic bundle_t dut_b();
        return mk(bus.alu_func, bus.alu_sub_en, bus.alu_din1, bus.alu_din2,
                  bus.rd, bus.rd_we, bus.illegal);
    endfunction

    // Reference: the ALU-executable subset of RV32I, expressed as a legality rule per opcode.
    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                           input logic [31:0] a, input logic [31:0] b);
        bundle_t     t;
        int unsigned op, f3, f7;
        logic        ok;
        op = 32'(i[6:0]);
        f3 = 32'(i[14:12]);
        f7 = 32'(i[31:25]);
        t  = '0;
        ok = 1'b0;
        t.rd = i[11:7];
        if (op == 'h33) begin
            ok = (f7 == 0 && f3 != 2) || (f7 == 'h20 && f3 == 0);
            t.func = 3'(f3); t.sub = (f7 == 'h20); t.d1 = a; t.d2 = b;
        end else if (op == 'h13) begin
            ok = (f3 != 2) && !((f3 == 1 || f3 == 5) && f7 != 0);
            t.func = 3'(f3); t.d1 = a; t.d2 = 32'($signed(i) >>> 20);
        end else if (op == 'h37) begin
            ok = 1'b1; t.d2 = i & 32'hFFFF_F000;
        end else if (op == 'h17) begin
            ok = 1'b1; t.d1 = p; t.d2 = i & 32'hFFFF_F000;
        end
        if (!ok) begin
            t.func = '0; t.sub = 1'b0; t.d1 = '0; t.d2 = '0;
        end
        t.ill = !ok;
        t.we  = ok && (t.rd != 0);
        return t;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k, s;
        w = $urandom();
        k = $urandom_range(0, 5);
        s = $urandom_range(0, 3);
        case (k)
            0, 4:    w[6:0] = 7'h33;
            1:       w[6:0] = 7'h13;
            2:       w[6:0] = 7'h37;
            3:       w[6:0] = 7'h17;
            default: ;
        endcase
        if (s == 0)      w[31:25] = 7'h00;
        else if (s == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input bundle_t exp);
        bundle_t act;
        act = dut_b();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got func=%h sub=%b d1=%h d2=%h rd=%0d we=%b ill=%b expected func=%h sub=%b d1=%h d2=%h rd=%0d we=%b ill=%b",
                     name, act.func, act.sub, act.d1, act.d2, act.rd, act.we, act.ill,
                     exp.func, exp.sub, exp.d1, exp.d2, exp.rd, exp.we, exp.ill);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instr     = i;
        bus.pc        = p;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic drive_vec(input int n, input logic ordy);
        drive(1'b1, vecs[n].instr, vecs[n].pc, vecs[n].a, vecs[n].b, ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int nvalid;
        logic rv, ro, fl;
        logic [31:0] ri, rp, ra, rb;

        vecs[0]  = '{32'h002081B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h5,   32'h7,        5'd3, 1'b1, 1'b0)};
        vecs[1]  = '{32'h402081B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b1, 32'h5,   32'h7,        5'd3, 1'b1, 1'b0)};
        vecs[2]  = '{32'hFFF00093, 32'h0,   32'h0,  32'h9,  mk(3'd0, 1'b0, 32'h0,   32'hFFFFFFFF, 5'd1, 1'b1, 1'b0)};
        vecs[3]  = '{32'h01F29293, 32'h0,   32'h1,  32'h9,  mk(3'd1, 1'b0, 32'h1,   32'h1F,       5'd5, 1'b1, 1'b0)};
        vecs[4]  = '{32'hABCDE3B7, 32'h0,   32'h11, 32'h22, mk(3'd0, 1'b0, 32'h0,   32'hABCDE000, 5'd7, 1'b1, 1'b0)};
        vecs[5]  = '{32'h00001117, 32'h100, 32'h11, 32'h22, mk(3'd0, 1'b0, 32'h100, 32'h1000,     5'd2, 1'b1, 1'b0)};
        vecs[6]  = '{32'h4020D1B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd3, 1'b0, 1'b1)};
        vecs[7]  = '{32'h0020A1B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd3, 1'b0, 1'b1)};
        vecs[8]  = '{32'h0000007F, 32'h40,  32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd0, 1'b0, 1'b1)};
        vecs[9]  = '{32'h00208033, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h5,   32'h7,        5'd0, 1'b0, 1'b0)};
        vecs[10] = '{32'h7FF0C213, 32'h0,   32'hF0, 32'h0,  mk(3'd4, 1'b0, 32'hF0,  32'h7FF,      5'd4, 1'b1, 1'b0)};
        vecs[11] = '{32'h4000D093, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd1, 1'b0, 1'b1)};
        vecs[12] = '{32'hFFE0B093, 32'h0,   32'h3,  32'h0,  mk(3'd3, 1'b0, 32'h3,   32'hFFFFFFFE, 5'd1, 1'b1, 1'b0)};
        vecs[13] = '{32'h0020F1B3, 32'h0,   32'hC,  32'hA,  mk(3'd7, 1'b0, 32'hC,   32'hA,        5'd3, 1'b1, 1'b0)};
        vecs[14] = '{32'h0220E1B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd3, 1'b0, 1'b1)};
        vecs[15] = '{32'h4020C1B3, 32'h0,   32'h5,  32'h7,  mk(3'd0, 1'b0, 32'h0,   32'h0,        5'd3, 1'b0, 1'b1)};

        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        do_reset();
        #1;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        chk_b("reset_bundle", '0);

        // Directed decode table, issued back-to-back.
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            drive_vec(n, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", n), 32'(bus.out_valid), 32'd1);
            chk_b($sformatf("vec%0d_bundle", n), vecs[n].exp);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk_b("drain_hold", vecs[15].exp);

        // Backpressure: A held for 3 stalled cycles while B waits.
        @(negedge clk);
        drive_vec(0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_vec(13, 1'b0);
            #1;
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk_b("stall_hold", vecs[0].exp);
        end
        @(negedge clk);
        drive_vec(13, 1'b1);
        #1;
        chk("unstall_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("unstall_valid", 32'(bus.out_valid), 32'd1);
        chk_b("unstall_issue", vecs[13].exp);

        // Stream of four with downstream always ready.
        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_vec(2 + k, 1'b1);
            @(posedge clk);
            #1;
            if (bus.out_valid) nvalid++;
            chk_b($sformatf("stream%0d", k), vecs[2 + k].exp);
        end
        chk("stream_count", 32'(nvalid), 32'd4);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_end", 32'(bus.out_valid), 32'd0);

        // Flush during stall with a competing new input.
        @(negedge clk);
        drive_vec(10, 1'b0);
        @(negedge clk);
        drive_vec(12, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk_b("flush_hold", vecs[10].exp);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_after", 32'(bus.out_valid), 32'd0);
        chk_b("flush_no_new", vecs[10].exp);

        // Reset in the middle of a stall.
        @(negedge clk);
        drive_vec(13, 1'b0);
        @(negedge clk);
        drive_vec(1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rststall_valid", 32'(bus.out_valid), 32'd0);
        chk("rststall_ready", 32'(bus.in_ready), 32'd1);
        chk_b("rststall_bundle", '0);
        @(negedge clk);
        rst = 1'b0;
        drive_vec(5, 1'b1);
        @(posedge clk);
        #1;
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);
        chk_b("postrst_issue", vecs[5].exp);

        // Random traffic against a one-entry buffer model.
        do_reset();
        m_valid = 1'b0;
        m_b     = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 15) == 0);
            ri = rand_instr();
            rp = $urandom();
            ra = $urandom();
            rb = $urandom();
            drive(rv, ri, rp, ra, rb, ro, fl);
            #1;
            chk("rnd_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("rnd_ready", 32'(bus.in_ready), 32'(!m_valid || ro));
            chk_b("rnd_bundle", m_b);
            if (fl) begin
                m_valid = 1'b0;
            end else if (rv && (!m_valid || ro)) begin
                m_valid = 1'b1;
                m_b     = ref_decode(ri, rp, ra, rb);
            end else if (m_valid && ro) begin
                m_valid = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
